// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the serial-in parallel-out deserializer.
//   sipo_state_t    - receive FSM states (PARITY used only with SIPO_PARITY_EN)
//   SIPO_WIDTH_DEF  - default data bits per frame
//   sipo_cnt_w()    - bit-counter width able to hold 0..WIDTH
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

    localparam int SIPO_WIDTH_DEF = 4;

    function automatic int sipo_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: WIDTH-bit shift register with selectable direction.
//   clk, rst  - clock, synchronous active-high reset
//   clr       - start from zero (with en: the shifted-in bit becomes bit 0 of a new word)
//   en        - shift din in this cycle
//   din       - serial bit
//   q_next    - value the register holds after this edge
// MSB_FIRST=1 shifts left with din entering the LSB; MSB_FIRST=0 shifts
// right with din entering the MSB.
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] base;

    always_comb begin
        base   = clr ? '0 : q;
        q_next = base;
        if (en) begin
            if (MSB_FIRST) q_next = {base[WIDTH-2:0], din};
            else           q_next = {din, base[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q_next;
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: receive end of the serial link. Collects WIDTH framed
// serial bits into a word and offers it on a valid/ready output; the shift
// register keeps accepting the next frame while the output word waits.
//   clk, rst    - clock, synchronous active-high reset
//   sin_valid   - sin carries a bit this cycle
//   sin         - serial data bit
//   sin_start   - with sin_valid: this bit is bit 0 of a frame (aborts any partial frame)
//   dout        - assembled word, stable while dout_valid
//   dout_valid  - dout holds an unconsumed word
//   dout_ready  - consumer takes dout when dout_valid
//   overrun     - 1-cycle pulse: a completed word was dropped
//   parity_err  - parity flag registered alongside dout
// Build option SIPO_PARITY_EN: each frame carries a trailing even-parity
// bit; parity_err = ^{data,parity}. Without it parity_err is tied 0.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             sin_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = sipo_cnt_w(WIDTH);

    sipo_state_t      state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             sh_en, sh_clr, done;
    logic [WIDTH-1:0] word;

    sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .clr    (sh_clr),
        .en     (sh_en),
        .din    (sin),
        .q_next (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start bit wins in every state: it restarts the frame with itself
    // as bit 0, silently discarding whatever was partially received.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_en     = 1'b0;
        sh_clr    = 1'b0;
        done      = 1'b0;
        if (sin_valid && sin_start) begin
            state_nxt = SHIFT;
            cnt_nxt   = CW'(1);
            sh_en     = 1'b1;
            sh_clr    = 1'b1;
        end else if (sin_valid) begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    sh_en   = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done      = 1'b1;
`endif
                    end
                end
                PARITY: begin
                    // Shift is idle here, so word still holds the data bits.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
`ifdef SIPO_PARITY_EN
                    done      = 1'b1;
`endif
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef SIPO_PARITY_EN
    logic perr_q;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // Output register: a completing word loads if the slot is empty or
    // being drained on this same edge; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= word;
                    dout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                    perr_q     <= ^{word, sin};
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
